// File: rtl/cache_req_ctrl_pkg.sv
// rtl/cache_req_ctrl_pkg.sv - shared state encoding and wait defaults for the cache request sequencer
package cache_req_pkg;

    // Cycles spent in HITCHK before the cache hit flag is trusted.
    localparam int DEF_HIT_WAIT  = 2;
    // Cycles held after a miss: cache miss states 1..10 plus the return to state 0.
    localparam int DEF_MISS_WAIT = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        HITCHK   = 3'd2,
        MISSWAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    // The wait counter only ever holds values up to (larger wait - 1).
    function automatic int wait_cnt_width(input int hit_wait, input int miss_wait);
        int top_val;
        top_val = (hit_wait > miss_wait) ? hit_wait : miss_wait;
        return (top_val > 1) ? $clog2(top_val) : 1;
    endfunction

endpackage

// File: rtl/cache_req_ctrl_sat_counter.sv
// rtl/cache_req_ctrl_sat_counter.sv - saturating event counter used for hit/miss statistics
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_req_ctrl.sv
// rtl/cache_req_ctrl.sv - CPU-side request sequencer in front of the 4-entry associative cache
module cache_req_ctrl
    import cache_req_pkg::*;
#(
    parameter int d_width   = 8,
    parameter int a_width   = 8,
    parameter int HIT_WAIT  = DEF_HIT_WAIT,
    parameter int MISS_WAIT = DEF_MISS_WAIT,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cpu_req,
    output logic               cpu_ready,
    input  logic               cpu_rw,
    input  logic [a_width-1:0] cpu_addr,
    input  logic [d_width-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [d_width-1:0] cpu_rdata,
    output logic               busy,
    output logic               c_enab,
    output logic               c_rw,
    output logic [a_width-1:0] c_addr,
    output logic [d_width-1:0] c_data_in,
    input  logic [d_width-1:0] c_data_out,
    input  logic               c_hit,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int WAIT_W = wait_cnt_width(HIT_WAIT, MISS_WAIT);

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;

    // Active access: drives the cache interface for the whole lookup.
    logic                act_rw;
    logic [a_width-1:0]  act_addr;
    logic [d_width-1:0]  act_wdata;

    // One-deep holding slot for a request that arrives while busy.
    logic                pend_valid;
    logic                pend_rw;
    logic [a_width-1:0]  pend_addr;
    logic [d_width-1:0]  pend_wdata;

    logic                accept;
    logic                take_pend;
    logic                take_req;
    logic                load_pend;
    logic                hit_inc;
    logic                miss_inc;
    logic                capture;

    assign cpu_ready = !pend_valid;
    assign accept    = cpu_req && cpu_ready;
    // Only an idle controller with an empty slot sends a new request straight to active.
    assign load_pend = accept && !take_req;
    assign busy      = (state != IDLE) || pend_valid;

    assign c_rw      = act_rw;
    assign c_addr    = act_addr;
    assign c_data_in = act_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, wait counter update, cache enable, ack and datapath strobes.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        c_enab    = 1'b0;
        cpu_ack   = 1'b0;
        take_pend = 1'b0;
        take_req  = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // A buffered request wins; cpu_ready is low then, so no new accept can collide.
                if (pend_valid) begin
                    take_pend = 1'b1;
                    state_nxt = ISSUE;
                end else if (accept) begin
                    take_req  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                c_enab    = 1'b1;
                wait_nxt  = WAIT_W'(HIT_WAIT - 1);
                state_nxt = HITCHK;
            end
            HITCHK: begin
                c_enab = 1'b1;
                if (wait_cnt != '0) begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end else if (c_hit) begin
                    hit_inc   = 1'b1;
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    miss_inc  = 1'b1;
                    wait_nxt  = WAIT_W'(MISS_WAIT - 1);
                    state_nxt = MISSWAIT;
                end
            end
            MISSWAIT: begin
                c_enab = 1'b1;
                if (wait_cnt != '0) begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end else begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Enable drops here so the cache falls back to its idle state between accesses.
                cpu_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

    // Pending slot: filled by any accept not taken straight to active, drained from IDLE.
    always_ff @(posedge clk) begin
        if (!clr) begin
            pend_valid <= 1'b0;
            pend_rw    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (take_pend) begin
            pend_valid <= 1'b0;
        end else if (load_pend) begin
            pend_valid <= 1'b1;
            pend_rw    <= cpu_rw;
            pend_addr  <= cpu_addr;
            pend_wdata <= cpu_wdata;
        end
    end

    // Active registers change only when an access is launched, keeping the cache inputs stable.
    always_ff @(posedge clk) begin
        if (!clr) begin
            act_rw    <= 1'b0;
            act_addr  <= '0;
            act_wdata <= '0;
        end else if (take_pend) begin
            act_rw    <= pend_rw;
            act_addr  <= pend_addr;
            act_wdata <= pend_wdata;
        end else if (take_req) begin
            act_rw    <= cpu_rw;
            act_addr  <= cpu_addr;
            act_wdata <= cpu_wdata;
        end
    end

    // Read data is captured on entry to DONE and held until the next read finishes.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cpu_rdata <= '0;
        end else if (capture && !act_rw) begin
            cpu_rdata <= c_data_out;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

endmodule

// File: tb/tb_cache_req_ctrl.sv
// tb/tb_cache_req_ctrl.sv - self-checking bench for cache_req_ctrl with a timeline model
module tb_cache_req_ctrl;
    import cache_req_pkg::*;

    localparam int HW   = DEF_HIT_WAIT;
    localparam int MW   = DEF_MISS_WAIT;
    localparam int MAXJ = 1024;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_rw = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ready, cpu_ack, busy, c_enab, c_rw, c_hit;
    logic [7:0] cpu_rdata, c_addr, c_data_in, c_data_out, hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    cache_req_ctrl #(
        .d_width(8), .a_width(8), .HIT_WAIT(HW), .MISS_WAIT(MW), .CNT_W(8)
    ) dut (
        .clk(clk), .clr(clr), .cpu_req(cpu_req), .cpu_ready(cpu_ready),
        .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .busy(busy),
        .c_enab(c_enab), .c_rw(c_rw), .c_addr(c_addr), .c_data_in(c_data_in),
        .c_data_out(c_data_out), .c_hit(c_hit), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Backing memory contents before any write.
    function automatic logic [7:0] mem_init(input logic [7:0] a);
        return (a == 8'h05) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    // Cache environment: an address becomes resident once an access to it completes.
    bit [255:0] env_present;
    bit [255:0] env_wr;
    bit [7:0]   env_wdat [256];

    assign c_hit      = env_present[c_addr];
    assign c_data_out = env_wr[c_addr] ? env_wdat[c_addr] : mem_init(c_addr);

    always @(posedge clk) begin
        if (!clr) begin
            env_present <= '0;
        end else if (cpu_ack) begin
            env_present[c_addr] <= 1'b1;
            if (c_rw) begin
                env_wr[c_addr]   <= 1'b1;
                env_wdat[c_addr] <= c_data_in;
            end
        end
    end

    // Timeline model: each accepted request becomes a job with absolute edge numbers.
    int         ecnt = 0;
    int         base = 0;
    int         nj = 0;
    int         last_ack = -100;
    int         j_acc [MAXJ];
    int         j_start [MAXJ];
    int         j_dec [MAXJ];
    int         j_ack [MAXJ];
    bit         j_hit [MAXJ];
    logic       j_rw [MAXJ];
    logic [7:0] j_addr [MAXJ];
    logic [7:0] j_wd [MAXJ];
    logic [7:0] j_rd [MAXJ];
    bit [255:0] m_present;
    bit [255:0] m_wr;
    logic [7:0] m_wdat [256];
    bit         acc_now = 0;
    int         acc_edge = 0;

    function automatic bit m_ready(input int e);
        for (int j = base; j < nj; j++)
            if (j_acc[j] <= e && e < j_start[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_busy(input int e);
        for (int j = base; j < nj; j++)
            if (j_acc[j] <= e && e <= j_ack[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ack(input int e);
        for (int j = base; j < nj; j++)
            if (j_ack[j] == e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_enab_idx(input int e);
        for (int j = base; j < nj; j++)
            if (j_start[j] <= e && e < j_ack[j]) return j;
        return -1;
    endfunction

    function automatic int m_count(input int e, input bit hits);
        int c;
        c = 0;
        for (int j = base; j < nj; j++)
            if (j_dec[j] <= e && j_hit[j] == hits) c++;
        return (c > 255) ? 255 : c;
    endfunction

    function automatic logic [7:0] m_rdata(input int e);
        logic [7:0] r;
        r = 8'h00;
        for (int j = base; j < nj; j++)
            if (!j_rw[j] && j_ack[j] <= e) r = j_rd[j];
        return r;
    endfunction

    task automatic model_step();
        int  e;
        int  s;
        bit  rdy;
        rdy     = m_ready(ecnt);
        e       = ecnt + 1;
        ecnt    = e;
        acc_now = 1'b0;
        if (!clr) begin
            base      = nj;
            last_ack  = -100;
            m_present = '0;
        end else if (cpu_req && rdy) begin
            s          = (e > last_ack + 2) ? e : last_ack + 2;
            j_acc[nj]  = e;
            j_start[nj] = s;
            j_dec[nj]  = s + HW + 1;
            j_hit[nj]  = m_present[cpu_addr];
            j_ack[nj]  = j_dec[nj] + (j_hit[nj] ? 0 : MW);
            j_rw[nj]   = cpu_rw;
            j_addr[nj] = cpu_addr;
            j_wd[nj]   = cpu_wdata;
            j_rd[nj]   = m_wr[cpu_addr] ? m_wdat[cpu_addr] : mem_init(cpu_addr);
            last_ack   = j_ack[nj];
            m_present[cpu_addr] = 1'b1;
            if (cpu_rw) begin
                m_wr[cpu_addr]   = 1'b1;
                m_wdat[cpu_addr] = cpu_wdata;
            end
            nj++;
            acc_now  = 1'b1;
            acc_edge = e;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int k;
        if (chk_en) begin
            k = m_enab_idx(ecnt);
            chk("cpu_ack",   32'(cpu_ack),   32'(m_ack(ecnt)));
            chk("cpu_ready", 32'(cpu_ready), 32'(m_ready(ecnt)));
            chk("busy",      32'(busy),      32'(m_busy(ecnt)));
            chk("c_enab",    32'(c_enab),    32'(k >= 0));
            if (k >= 0) begin
                chk("c_rw",      32'(c_rw),      32'(j_rw[k]));
                chk("c_addr",    32'(c_addr),    32'(j_addr[k]));
                chk("c_data_in", 32'(c_data_in), 32'(j_wd[k]));
            end
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata(ecnt)));
            chk("hit_cnt",   32'(hit_cnt),   32'(m_count(ecnt, 1'b1)));
            chk("miss_cnt",  32'(miss_cnt),  32'(m_count(ecnt, 1'b0)));
        end
    end

    int ack_q[$];

    always @(negedge clk) begin
        if (chk_en && cpu_ack) ack_q.push_back(ecnt);
    end

    task automatic send(input logic rw, input logic [7:0] a, input logic [7:0] d, output int acc_e);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = d;
        acc_e     = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc_e = acc_edge;
                break;
            end
        end
        cpu_req = 1'b0;
        if (acc_e < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: addr %0h never accepted", a);
        end
    endtask

    task automatic wait_acks(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (ack_q.size() >= n) break;
            @(negedge clk);
        end
        if (ack_q.size() < n) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", ack_q.size(), n);
            while (ack_q.size() < n) ack_q.push_back(-1000);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, aa, ab, ac, x;
        clr = 1'b0;
        idle(2);
        chk_en = 1'b1;
        chk("rst_c_enab",    32'(c_enab),    32'd0);
        chk("rst_c_addr",    32'(c_addr),    32'd0);
        chk("rst_c_data_in", 32'(c_data_in), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        clr = 1'b1;
        idle(2);

        // Preload 0x03 by a miss, then read it back as a hit.
        ack_q.delete();
        send(1'b0, 8'h03, 8'h00, a0);
        wait_acks(1, 100);
        idle(2);
        send(1'b0, 8'h03, 8'h00, a1);
        wait_acks(2, 100);
        chk("t1_miss_latency", 32'(ack_q[0] - a0), 32'd14);
        chk("t1_hit_latency",  32'(ack_q[1] - a1), 32'd3);
        chk("t1_rdata",        32'(cpu_rdata),     32'h59);
        chk("t1_hit_cnt",      32'(hit_cnt),       32'd1);
        chk("t1_miss_cnt",     32'(miss_cnt),      32'd1);

        // Miss on 0x05 returns 0xA5 after the full miss latency.
        idle(2);
        ack_q.delete();
        send(1'b0, 8'h05, 8'h00, a0);
        wait_acks(1, 100);
        chk("t2_latency",  32'(ack_q[0] - a0), 32'd14);
        chk("t2_rdata",    32'(cpu_rdata),     32'hA5);
        chk("t2_miss_cnt", 32'(miss_cnt),      32'd2);

        // Install 0x01, then write 0x3C to it as a hit; read data must not move.
        idle(2);
        ack_q.delete();
        send(1'b0, 8'h01, 8'h00, a0);
        wait_acks(1, 100);
        idle(2);
        send(1'b1, 8'h01, 8'h3C, a1);
        wait_acks(2, 100);
        chk("t3_wr_latency", 32'(ack_q[1] - a1), 32'd3);
        chk("t3_rdata_kept", 32'(cpu_rdata),     32'h5B);
        chk("t3_hit_cnt",    32'(hit_cnt),       32'd2);
        chk("t3_miss_cnt",   32'(miss_cnt),      32'd3);

        // A miss, B buffered one cycle later, C held off until B leaves the slot.
        idle(2);
        ack_q.delete();
        send(1'b0, 8'h10, 8'h00, aa);
        send(1'b0, 8'h03, 8'h00, ab);
        chk("t4_b_accept", 32'(ab - aa),    32'd1);
        chk("t4_b_ready",  32'(cpu_ready),  32'd0);
        send(1'b0, 8'h05, 8'h00, ac);
        wait_acks(3, 200);
        chk("t4_a_latency", 32'(ack_q[0] - aa), 32'd14);
        chk("t4_c_accept",  32'(ac - ack_q[0]), 32'd3);
        chk("t4_ab_gap",    32'(ack_q[1] - ack_q[0]), 32'd5);
        chk("t4_bc_gap",    32'(ack_q[2] - ack_q[1]), 32'd5);
        chk("t4_rdata",     32'(cpu_rdata), 32'hA5);
        chk("t4_hit_cnt",   32'(hit_cnt),   32'd4);
        chk("t4_miss_cnt",  32'(miss_cnt),  32'd4);

        // Reset during the fifth MISSWAIT cycle aborts the access.
        idle(2);
        ack_q.delete();
        send(1'b0, 8'h20, 8'h00, a0);
        for (int i = 0; i < 50 && ecnt < a0 + 7; i++) @(negedge clk);
        chk("t5_pre_enab", 32'(c_enab),   32'd1);
        chk("t5_pre_miss", 32'(miss_cnt), 32'd5);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        chk("t5_enab",  32'(c_enab),    32'd0);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_ack",   32'(cpu_ack),   32'd0);
        chk("t5_hit",   32'(hit_cnt),   32'd0);
        chk("t5_miss",  32'(miss_cnt),  32'd0);
        chk("t5_rdata", 32'(cpu_rdata), 32'd0);
        idle(20);
        chk("t5_no_ack", 32'(ack_q.size()), 32'd0);
        send(1'b0, 8'h03, 8'h00, a1);
        wait_acks(1, 100);
        chk("t5_latency", 32'(ack_q[0] - a1), 32'd14);
        chk("t5_rdata2",  32'(cpu_rdata),     32'h59);
        chk("t5_miss2",   32'(miss_cnt),      32'd1);

        // 260 back-to-back hits saturate the hit counter.
        idle(2);
        ack_q.delete();
        for (int i = 0; i < 260; i++) send(1'b0, 8'h03, 8'h00, x);
        wait_acks(260, 3000);
        idle(2);
        chk("t6_hit_sat", 32'(hit_cnt),  32'd255);
        chk("t6_miss",    32'(miss_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
